// File: rtl/tsn_gate_scheduler.sv
// -----------------------------------------------------------------------------
// tsn_gate_scheduler
//
// Time-aware gate scheduler for the TSN egress path. It runs a gate control
// list (GCL) against the 1588 time base and drives per-queue transmit gates.
// The GCL is double banked. Software writes the shadow bank, and an apply
// swaps the banks atomically. In IDLE the swap happens at once and the list
// starts when ptp_ns reaches the base time. In RUN the swap waits for the
// next cycle wrap.
//
// Ports
//   syc_clk_250m  sole clock
//   sys_reset     synchronous active-high reset
//   ptp_ns        current PTP time in ns (advances TICK_NS per clock)
//   gcl_wr_en     write one shadow-bank entry
//   gcl_wr_addr   shadow entry index
//   gcl_wr_data   {gate_mask, interval_ns[31:0]}
//   cfg_len       number of valid entries in the shadow list
//   cfg_cycle_ns  cycle time in ns
//   cfg_base_ns   base time in ns (used only when activating from IDLE/WAIT)
//   cfg_apply     pulse: sample cfg_* and request activation
//   gate_states   registered gate mask, 1 = open
//   entry_idx     active entry index
//   cycle_start   one-cycle pulse when entry 0 is loaded
//   running       high while the list is executing
//   cfg_pending   an applied config is waiting for the next wrap
//   cfg_err       one-cycle pulse on a rejected apply
// -----------------------------------------------------------------------------
module tsn_gate_scheduler #(
    parameter int NUM_QUEUES = 8,
    parameter int GCL_DEPTH  = 16,
    parameter int TICK_NS    = 4
) (
    input  logic                          syc_clk_250m,
    input  logic                          sys_reset,
    input  logic [63:0]                   ptp_ns,
    input  logic                          gcl_wr_en,
    input  logic [$clog2(GCL_DEPTH)-1:0]  gcl_wr_addr,
    input  logic [NUM_QUEUES+31:0]        gcl_wr_data,
    input  logic [$clog2(GCL_DEPTH):0]    cfg_len,
    input  logic [31:0]                   cfg_cycle_ns,
    input  logic [63:0]                   cfg_base_ns,
    input  logic                          cfg_apply,
    output logic [NUM_QUEUES-1:0]         gate_states,
    output logic [$clog2(GCL_DEPTH)-1:0]  entry_idx,
    output logic                          cycle_start,
    output logic                          running,
    output logic                          cfg_pending,
    output logic                          cfg_err
);
    localparam int            AW      = $clog2(GCL_DEPTH);
    localparam int            DW      = NUM_QUEUES + 32;
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(GCL_DEPTH);
    localparam logic [31:0]   TICK_L  = 32'(TICK_NS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_BASE, ST_RUN} state_t;

    state_t                 state_reg, state_next;
    logic                   bank_reg, bank_next;
    logic [AW:0]            len_reg, len_next;
    logic [31:0]            cycle_reg, cycle_next;
    logic [63:0]            base_reg, base_next;
    logic [AW:0]            pend_len_reg, pend_len_next;
    logic [31:0]            pend_cycle_reg, pend_cycle_next;
    logic                   pending_reg, pending_next;
    logic [31:0]            remaining_reg, remaining_next;
    logic [31:0]            elapsed_reg, elapsed_next;
    logic [AW-1:0]          idx_reg, idx_next;
    logic [NUM_QUEUES-1:0]  gates_reg, gates_next;
    logic                   cycle_start_reg, cycle_start_next;
    logic                   cfg_err_reg, cfg_err_next;

    // Both banks live in one array; the bank bit is the address MSB.
    logic [DW-1:0]          gcl_mem [0:2*GCL_DEPTH-1];

    // Writes always land in the shadow bank (the one not being executed).
    always_ff @(posedge syc_clk_250m) begin
        if (gcl_wr_en) begin
            gcl_mem[{~bank_reg, gcl_wr_addr}] <= gcl_wr_data;
        end
    end

    logic         apply_valid;
    logic [32:0]  elapsed_sum;
    logic         cyc_end;
    logic         ent_end;
    logic         is_last;
    logic [31:0]  elapsed_inc;
    logic [31:0]  rem_dec;

    assign apply_valid = cfg_apply && (cfg_len != '0) && (cfg_len <= DEPTH_L)
                         && (cfg_cycle_ns != 32'd0);
    assign elapsed_sum = {1'b0, elapsed_reg} + {1'b0, TICK_L};
    assign cyc_end     = (elapsed_sum >= {1'b0, cycle_reg});
    assign ent_end     = (remaining_reg <= TICK_L);
    assign is_last     = ({1'b0, idx_reg} == (len_reg - 1'b1));
    assign elapsed_inc = elapsed_sum[32] ? 32'hFFFF_FFFF : elapsed_sum[31:0];
    assign rem_dec     = (remaining_reg > TICK_L) ? (remaining_reg - TICK_L) : 32'd0;

    // The entry to load must be known in the same cycle its condition is seen
    // (one-clock condition-to-gate latency), so the list is read without a
    // pipeline register. A wrap that also swaps banks reads entry 0 of the
    // incoming bank.
    logic           load_bank;
    logic [AW-1:0]  load_addr;
    logic           wr_hit;
    logic [DW-1:0]  load_word;

    always_comb begin
        load_bank = bank_reg;
        load_addr = idx_reg + AW'(1);
        if (state_reg == ST_WAIT_BASE) begin
            load_addr = '0;
        end else if ((state_reg == ST_RUN) && cyc_end) begin
            load_addr = '0;
            if (apply_valid || pending_reg) begin
                load_bank = ~bank_reg;
            end
        end
    end

    // A write issued in the swap cycle must be seen by the entry loaded at
    // that same edge, so forward it around the array.
    assign wr_hit    = gcl_wr_en && (load_bank == ~bank_reg) && (gcl_wr_addr == load_addr);
    assign load_word = wr_hit ? gcl_wr_data : gcl_mem[{load_bank, load_addr}];

    always_comb begin
        state_next       = state_reg;
        bank_next        = bank_reg;
        len_next         = len_reg;
        cycle_next       = cycle_reg;
        base_next        = base_reg;
        pend_len_next    = pend_len_reg;
        pend_cycle_next  = pend_cycle_reg;
        pending_next     = pending_reg;
        remaining_next   = remaining_reg;
        elapsed_next     = elapsed_reg;
        idx_next         = idx_reg;
        gates_next       = gates_reg;
        cycle_start_next = 1'b0;
        cfg_err_next     = cfg_apply && !apply_valid;

        case (state_reg)
            ST_IDLE: begin
                gates_next = '1;
                if (apply_valid) begin
                    bank_next  = ~bank_reg;
                    len_next   = cfg_len;
                    cycle_next = cfg_cycle_ns;
                    base_next  = cfg_base_ns;
                    state_next = ST_WAIT_BASE;
                end
            end
            ST_WAIT_BASE: begin
                if (apply_valid) begin
                    // Re-swap and restart the wait against the new base.
                    bank_next  = ~bank_reg;
                    len_next   = cfg_len;
                    cycle_next = cfg_cycle_ns;
                    base_next  = cfg_base_ns;
                end else if (ptp_ns >= base_reg) begin
                    state_next       = ST_RUN;
                    idx_next         = '0;
                    gates_next       = load_word[DW-1:32];
                    remaining_next   = load_word[31:0];
                    elapsed_next     = 32'd0;
                    cycle_start_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (cyc_end) begin
                    // Wrap takes priority over an entry ending in the same cycle.
                    idx_next         = '0;
                    gates_next       = load_word[DW-1:32];
                    remaining_next   = load_word[31:0];
                    elapsed_next     = 32'd0;
                    cycle_start_next = 1'b1;
                    if (apply_valid) begin
                        // An apply landing on the wrap supersedes any pending one.
                        bank_next    = ~bank_reg;
                        len_next     = cfg_len;
                        cycle_next   = cfg_cycle_ns;
                        pending_next = 1'b0;
                    end else if (pending_reg) begin
                        bank_next    = ~bank_reg;
                        len_next     = pend_len_reg;
                        cycle_next   = pend_cycle_reg;
                        pending_next = 1'b0;
                    end
                end else begin
                    elapsed_next = elapsed_inc;
                    if (ent_end && !is_last) begin
                        idx_next       = idx_reg + AW'(1);
                        gates_next     = load_word[DW-1:32];
                        remaining_next = load_word[31:0];
                    end else begin
                        // Also covers the last entry holding its mask until the wrap.
                        remaining_next = rem_dec;
                    end
                    if (apply_valid) begin
                        pend_len_next   = cfg_len;
                        pend_cycle_next = cfg_cycle_ns;
                        pending_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge syc_clk_250m) begin
        if (sys_reset) begin
            state_reg       <= ST_IDLE;
            bank_reg        <= 1'b0;
            len_reg         <= '0;
            cycle_reg       <= 32'd0;
            base_reg        <= 64'd0;
            pend_len_reg    <= '0;
            pend_cycle_reg  <= 32'd0;
            pending_reg     <= 1'b0;
            remaining_reg   <= 32'd0;
            elapsed_reg     <= 32'd0;
            idx_reg         <= '0;
            gates_reg       <= '1;
            cycle_start_reg <= 1'b0;
            cfg_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bank_reg        <= bank_next;
            len_reg         <= len_next;
            cycle_reg       <= cycle_next;
            base_reg        <= base_next;
            pend_len_reg    <= pend_len_next;
            pend_cycle_reg  <= pend_cycle_next;
            pending_reg     <= pending_next;
            remaining_reg   <= remaining_next;
            elapsed_reg     <= elapsed_next;
            idx_reg         <= idx_next;
            gates_reg       <= gates_next;
            cycle_start_reg <= cycle_start_next;
            cfg_err_reg     <= cfg_err_next;
        end
    end

    assign gate_states = gates_reg;
    assign entry_idx   = idx_reg;
    assign cycle_start = cycle_start_reg;
    assign running     = (state_reg == ST_RUN);
    assign cfg_pending = pending_reg;
    assign cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_tsn_gate_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tsn_gate_scheduler
//
// Drives tsn_gate_scheduler one clock at a time with a ramping PTP time. Each
// clock, a schedule model computes the expected outputs for the next edge and
// pushes them to a queue. After the edge they are popped and compared. The
// model derives the gate mask from the entry start offsets within the cycle
// period, both computed in whole clocks.
// -----------------------------------------------------------------------------
module tb_tsn_gate_scheduler;
    logic         clk = 1'b0;
    logic         sys_reset = 1'b0;
    logic [63:0]  ptp_ns = 64'd0;
    logic         gcl_wr_en = 1'b0;
    logic [3:0]   gcl_wr_addr = 4'd0;
    logic [39:0]  gcl_wr_data = 40'd0;
    logic [4:0]   cfg_len = 5'd0;
    logic [31:0]  cfg_cycle_ns = 32'd0;
    logic [63:0]  cfg_base_ns = 64'd0;
    logic         cfg_apply = 1'b0;
    logic [7:0]   gate_states;
    logic [3:0]   entry_idx;
    logic         cycle_start, running, cfg_pending, cfg_err;

    tsn_gate_scheduler #(.NUM_QUEUES(8), .GCL_DEPTH(16), .TICK_NS(4)) dut (
        .syc_clk_250m (clk),
        .sys_reset    (sys_reset),
        .ptp_ns       (ptp_ns),
        .gcl_wr_en    (gcl_wr_en),
        .gcl_wr_addr  (gcl_wr_addr),
        .gcl_wr_data  (gcl_wr_data),
        .cfg_len      (cfg_len),
        .cfg_cycle_ns (cfg_cycle_ns),
        .cfg_base_ns  (cfg_base_ns),
        .cfg_apply    (cfg_apply),
        .gate_states  (gate_states),
        .entry_idx    (entry_idx),
        .cycle_start  (cycle_start),
        .running      (running),
        .cfg_pending  (cfg_pending),
        .cfg_err      (cfg_err)
    );

    always #2 clk = ~clk;

    typedef struct packed {
        logic [7:0] gates;
        logic       start;
        logic       run;
        logic [3:0] idx;
        logic       pend;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    // Stimulus for the next clock, cleared after every step.
    logic        s_rst = 1'b0, s_apply = 1'b0, s_wr = 1'b0;
    logic [4:0]  s_len = 5'd0;
    logic [31:0] s_cycle = 32'd0;
    logic [63:0] s_base = 64'd0;
    logic [3:0]  s_waddr = 4'd0;
    logic [39:0] s_wdata = 40'd0;
    logic [63:0] ptp_val = 64'd0;

    // Schedule model state.
    logic [39:0] mdl_mem [0:1][0:15];
    logic        mdl_bank = 1'b0;
    logic        mdl_wait = 1'b0, mdl_run = 1'b0, mdl_pend = 1'b0;
    int          mdl_len = 0, mdl_period = 1, mdl_t = 0;
    int          pend_len = 0, pend_period = 1;
    logic [63:0] mdl_base = 64'd0;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int clocks_of(input logic [31:0] ns);
        return (ns == 32'd0) ? 1 : int'((longint'(ns) + 3) / 4);
    endfunction

    task automatic mdl_install(input logic [4:0] len, input logic [31:0] cyc);
        mdl_bank   = ~mdl_bank;
        mdl_len    = int'(len);
        mdl_period = clocks_of(cyc);
    endtask

    // Entry active at clock offset t of the current period.
    task automatic mdl_lookup(input int t, output logic [7:0] mask, output int k);
        longint s = 0;
        k = 0;
        for (int j = 0; j < mdl_len; j++) begin
            if (s <= longint'(t)) k = j;
            s += longint'(clocks_of(mdl_mem[mdl_bank][j][31:0]));
        end
        mask = mdl_mem[mdl_bank][k][39:32];
    endtask

    task automatic step();
        logic valid;
        logic [7:0] m;
        int k;
        exp_t e, got_e;
        @(negedge clk);
        sys_reset    = s_rst;
        cfg_apply    = s_apply;
        cfg_len      = s_len;
        cfg_cycle_ns = s_cycle;
        cfg_base_ns  = s_base;
        gcl_wr_en    = s_wr;
        gcl_wr_addr  = s_waddr;
        gcl_wr_data  = s_wdata;
        ptp_ns       = ptp_val;

        if (s_wr) mdl_mem[~mdl_bank][s_waddr] = s_wdata;
        valid = s_apply && (s_len != 5'd0) && (s_len <= 5'd16) && (s_cycle != 32'd0);
        e = '0;
        e.err = s_apply && !valid;
        if (s_rst) begin
            mdl_run = 1'b0; mdl_wait = 1'b0; mdl_pend = 1'b0; mdl_bank = 1'b0; mdl_t = 0;
            e.err = 1'b0;
        end else if (mdl_run) begin
            mdl_t++;
            if (mdl_t >= mdl_period) begin
                mdl_t = 0;
                if (valid) begin
                    mdl_install(s_len, s_cycle);
                    mdl_pend = 1'b0;
                end else if (mdl_pend) begin
                    mdl_bank = ~mdl_bank; mdl_len = pend_len; mdl_period = pend_period;
                    mdl_pend = 1'b0;
                end
            end else if (valid) begin
                pend_len = int'(s_len); pend_period = clocks_of(s_cycle); mdl_pend = 1'b1;
            end
        end else if (mdl_wait) begin
            if (valid) begin
                mdl_install(s_len, s_cycle); mdl_base = s_base;
            end else if (ptp_val >= mdl_base) begin
                mdl_run = 1'b1; mdl_t = 0;
            end
        end else if (valid) begin
            mdl_install(s_len, s_cycle); mdl_base = s_base; mdl_wait = 1'b1;
        end

        if (mdl_run) begin
            mdl_lookup(mdl_t, m, k);
            e.gates = m; e.idx = 4'(k); e.start = (mdl_t == 0);
        end else begin
            e.gates = 8'hFF; e.idx = 4'd0; e.start = 1'b0;
        end
        e.run  = mdl_run;
        e.pend = mdl_pend;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        got_e = exp_q.pop_front();
        chk_val("gate_states", 64'(gate_states), 64'(got_e.gates));
        chk_val("cycle_start", 64'(cycle_start), 64'(got_e.start));
        chk_val("running",     64'(running),     64'(got_e.run));
        chk_val("entry_idx",   64'(entry_idx),   64'(got_e.idx));
        chk_val("cfg_pending", 64'(cfg_pending), 64'(got_e.pend));
        chk_val("cfg_err",     64'(cfg_err),     64'(got_e.err));

        ptp_val += 64'd4;
        s_rst = 1'b0; s_apply = 1'b0; s_wr = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        $display("reset at ptp=%0d", ptp_val);
        s_rst = 1'b1;
        step();
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic [7:0] mask, input logic [31:0] iv);
        $display("write entry %0d mask=%02h interval=%0d", addr, mask, iv);
        s_wr = 1'b1; s_waddr = addr; s_wdata = {mask, iv};
        step();
    endtask

    // Optionally writes one entry in the same clock as the apply.
    task automatic apply_cfg(input logic [4:0] len, input logic [31:0] cyc, input logic [63:0] base,
                             input logic wr, input logic [3:0] addr, input logic [39:0] data);
        $display("apply len=%0d cycle=%0d base=%0d at ptp=%0d wr=%0b", len, cyc, base, ptp_val, wr);
        s_apply = 1'b1; s_len = len; s_cycle = cyc; s_base = base;
        s_wr = wr; s_waddr = addr; s_wdata = data;
        step();
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 16; a++)
                mdl_mem[b][a] = 40'd0;

        // Reset and idle with ptp ramping: gates open, nothing runs.
        s_rst = 1'b1; step();
        do_reset();
        run_cycles(100);

        // Basic schedule: 10 clocks of 0x01, 15 of 0x80, period 25.
        write_entry(4'd0, 8'h01, 32'd40);
        write_entry(4'd1, 8'h80, 32'd60);
        apply_cfg(5'd2, 32'd100, 64'd1000, 1'b0, 4'd0, 40'd0);
        run_cycles(220);

        // Truncation: cycle 60 cuts entry 1 to 5 clocks. Entry 1 is rewritten
        // in the apply clock to exercise write-before-swap.
        do_reset();
        apply_cfg(5'd2, 32'd60, ptp_val + 64'd40, 1'b1, 4'd1, {8'h80, 32'd60});
        run_cycles(60);

        // Extension: cycle 200, base in the past, 0x80 held 40 clocks.
        do_reset();
        apply_cfg(5'd2, 32'd200, 64'd0, 1'b0, 4'd0, 40'd0);
        run_cycles(120);

        // Mid-run reconfig, last apply wins: pending until the wrap, then 0x0F
        // with a 5-clock period.
        write_entry(4'd0, 8'h0F, 32'd20);
        apply_cfg(5'd1, 32'd40, 64'd0, 1'b0, 4'd0, 40'd0);
        apply_cfg(5'd1, 32'd20, 64'd0, 1'b0, 4'd0, 40'd0);
        run_cycles(70);

        // Re-apply while waiting for the base: the wait restarts on the new base.
        do_reset();
        apply_cfg(5'd2, 32'd100, ptp_val + 64'd100000, 1'b0, 4'd0, 40'd0);
        run_cycles(5);
        apply_cfg(5'd1, 32'd20, ptp_val + 64'd40, 1'b0, 4'd0, 40'd0);
        run_cycles(40);

        // Rejected applies leave the running schedule untouched.
        apply_cfg(5'd0, 32'd20, 64'd0, 1'b0, 4'd0, 40'd0);
        run_cycles(3);
        apply_cfg(5'd17, 32'd20, 64'd0, 1'b0, 4'd0, 40'd0);
        run_cycles(3);
        apply_cfg(5'd1, 32'd0, 64'd0, 1'b0, 4'd0, 40'd0);
        run_cycles(12);

        // Reset in the middle of RUN.
        do_reset();
        run_cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/tsn_gate_scheduler.md
# tsn_gate_scheduler

Time-aware gate scheduler for the TSN egress path. It executes an 802.1Qbv-style gate control list (GCL) against the 1588 time base and drives per-queue transmit gate states to the egress queue selector. GCL contents are written into a shadow bank and activated atomically, either at a base time or at the next cycle boundary. It sits beside the hardware 1588 engine, in the same `syc_clk_250m` domain.

## Interface
Parameters:
- NUM_QUEUES, 8, number of traffic-class gates
- GCL_DEPTH, 16, entries per bank (power of two)
- TICK_NS, 4, nanoseconds per clock (250 MHz)

Ports (one clock; reset is synchronous and active-high):
- syc_clk_250m  in  1  sole clock
- sys_reset  in  1  synchronous, active-high reset
- ptp_ns  in  64  current PTP time in ns, advancing TICK_NS per clock
- gcl_wr_en  in  1  write one shadow-bank entry
- gcl_wr_addr  in  log2(GCL_DEPTH)  entry index
- gcl_wr_data  in  NUM_QUEUES+32  {gate_mask, interval_ns[31:0]}
- cfg_len  in  log2(GCL_DEPTH)+1  valid entries in the shadow list
- cfg_cycle_ns  in  32  cycle time in ns
- cfg_base_ns  in  64  base time in ns
- cfg_apply  in  1  pulse; samples cfg_* and requests activation
- gate_states  out  NUM_QUEUES  registered gate mask, 1 = open
- entry_idx  out  log2(GCL_DEPTH)  active entry
- cycle_start  out  1  one-cycle pulse when entry 0 is loaded
- running  out  1  high in RUN
- cfg_pending  out  1  applied config waiting for its boundary
- cfg_err  out  1  one-cycle pulse on a rejected apply

## Operation
- Two GCL banks. Writes always go to the shadow bank. Activation swaps the active and shadow banks and latches len, cycle and base.
- An apply with cfg_len==0, cfg_len>GCL_DEPTH or cfg_cycle_ns==0 is rejected: cfg_err pulses and no other state changes.
- States:
  - IDLE: gate_states = all ones. On a valid apply, swap banks and go to WAIT_BASE.
  - WAIT_BASE: on the first cycle with ptp_ns >= base, go to RUN. This includes the first cycle after apply if base is already in the past; there is no projection to a future cycle.
  - RUN: executes the list as described below.
- On entry to RUN, and at every wrap: load entry 0, set remaining = interval0, set elapsed = 0, pulse cycle_start.
- Each RUN cycle: remaining -= TICK_NS and elapsed += TICK_NS.
- The entry ends in the cycle where remaining <= TICK_NS. An entry therefore lasts max(1, ceil(interval/TICK_NS)) cycles; interval 0 counts as one cycle.
- The cycle ends in the cycle where elapsed+TICK_NS >= cycle_ns. It wraps regardless of entry position, which truncates the list.
- If the last entry (len-1) expires before the cycle ends, hold that entry's gate_mask until the wrap. The list is never re-run within one cycle.
- Priority when an entry end and a cycle end coincide: wrap wins.
- Apply while in RUN (valid): set cfg_pending. At the next wrap, swap banks, use the new len and cycle, and clear cfg_pending. The new base is ignored.
- Apply while cfg_pending is already set: overwrite the pending len and cycle (last one wins).
- Apply while in WAIT_BASE: re-swap banks and restart the wait with the new base.
- Width rules:
  - remaining and elapsed are 32-bit unsigned and saturate at 0 / 2^32-1.
  - ptp_ns compare is 64-bit unsigned.

## Timing
- Reset values:
  - gate_states = all ones; entry_idx = 0.
  - cycle_start, running, cfg_pending, cfg_err = 0.
  - State = IDLE; the active bank pointer is bank 0.
  - GCL RAM contents are not reset.
- Condition to output latency is one clock for all outputs:
  - ptp_ns >= base seen at edge N: gate_states = entry0 mask, cycle_start = 1 and running = 1 at edge N+1.
  - Entry change: the new mask is visible on the edge after the expiry cycle.
- Apply to cfg_err or cfg_pending: one clock.
- A gcl_wr_en issued in the same cycle as cfg_apply is included in the swapped bank (write-before-swap).
- sys_reset in any state returns every output to its reset value on the next edge.

## Test plan
- Reset -> gate_states=8'hFF, running=0, entry_idx=0, and no cycle_start for 100 cycles with ptp ramping.
- Basic schedule: GCL {8'h01,40}, {8'h80,60}; len=2, cycle=100, base=1000; ptp from 0 step 4 -> at the edge after ptp=1000, gates=8'h01 with cycle_start. 10 cycles later gates=8'h80. 15 cycles later gates=8'h01 with cycle_start. Period is 25 cycles.
- Truncation: same list with cycle=60 -> entry 1 lasts 5 cycles. cycle_start every 15 cycles.
- Extension: same list with cycle=200 -> 8'h80 held for 40 cycles. Period is 50 cycles.
- Mid-run reconfig: while running, write {8'h0F,20} to the shadow bank, apply len=1, cycle=20 -> cfg_pending=1 until the next wrap. Then gates=8'h0F with a 5-cycle period.
- Errors and reset: apply with len=0 -> one cfg_err pulse and the schedule is unaffected. Assert sys_reset mid-RUN -> gates=8'hFF and running=0 on the next edge.
